uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//  Serial front end of the UART receive path: synchronises rx_serial, oversamples 16x, frames start/8 data/stop.
//  Presents the byte on rx_data with level rx_rdy (low while a frame is in flight, high when a byte is valid).
//  rx_mainFSM consumes rx_data and rx_rdy directly, so rx_rdy follows its low-then-high handshake.
// PARAMETERS
//  BAUD_DIV    27  clka cycles per 16x oversample tick (>=2); bit time = 16*BAUD_DIV cycles
//  PARITY_ODD  0   with UART_RX_PARITY_EN: 0 = even parity, 1 = odd parity; otherwise unused
// PORTS
//  clka        in   1  single clock; all logic on posedge clka
//  reset       in   1  synchronous, active-high; wins over every other event in the same cycle
//  rx_serial   in   1  asynchronous serial line, idle high
//  rx_data     out  8  last received byte, LSB first on the line; holds until the next frame completes
//  rx_rdy      out  1  1 = idle/byte valid; 0 from start-bit confirmation until the frame completes
//  rx_valid    out  1  one-cycle pulse in the cycle rx_data updates
//  rx_active   out  1  1 in any state other than IDLE
//  frame_err   out  1  stop bit sampled 0; held until the next start-bit confirmation
//  parity_err  out  1  parity mismatch; held until the next start-bit confirmation; tied 0 without the macro
// BEHAVIOUR
//  Reset values: rx_data=0, rx_rdy=1, rx_valid=0, rx_active=0, frame_err=0, parity_err=0.
//    Synchroniser flops=1, state=IDLE, all counters=0.
//  Synchroniser: 2-flop chain on rx_serial (reset to 1); all decisions use the 2nd flop (rxs).
//  Tick: divider counts 0..BAUD_DIV-1 and pulses tick on BAUD_DIV-1. The divider is cleared on start-edge detect.
//  Sample counter scnt: 4 bits, advances on tick, wraps 15->0. bcnt: 3-bit data bit index.
//  States:
//   IDLE:  rxs==0 -> START; clear divider and scnt.
//   START: on tick with scnt==7 (start-bit midpoint):
//          rxs==0 -> DATA; scnt=0, bcnt=0, rx_rdy=0, frame_err=0, parity_err=0.
//          rxs==1 -> IDLE (glitch reject); no output changes.
//   DATA:  on tick with scnt==15: shift rxs into shreg[7] (right shift, LSB first) and bcnt++.
//          After bcnt==7 is sampled -> PARITY if the macro is defined, else STOP.
//   PARITY: on tick with scnt==15: compare rxs with the expected parity bit; set parity_err on mismatch -> STOP.
//   STOP:  on tick with scnt==15, in the same cycle: rx_data<=shreg, rx_valid=1, rx_rdy=1.
//          rxs==1 -> IDLE.
//          rxs==0 -> frame_err=1 -> BREAK.
//   BREAK: wait for rxs==1 -> IDLE; no new start edge is accepted while the line is held low.
//  Byte delivered on errors: rx_data is updated even on a framing or parity error; the error flag qualifies it.
//  Latency: rx_valid asserts 1 cycle after the stop-bit midpoint tick is registered.
//    This is ~9.5 bit times (10.5 with parity) after the start edge, plus 2 synchroniser cycles.
//  Back-to-back frames: a start edge is accepted in IDLE the cycle after STOP; no idle bit is required.
//  Reset mid-frame: the frame is aborted, all outputs take their reset values, and no rx_valid is issued.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - Frame is start/8 data/parity/stop.
//   - Expected parity bit = ^shreg ^ PARITY_ODD.
//   - parity_err is live.
//  UART_RX_PARITY_EN undefined:
//   - Frame is start/8 data/stop; the PARITY state is not built.
//   - parity_err is constant 0.
// STRUCTURE
//  uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK) and OVERSAMPLE=16.
//    Also MID_SAMPLE=7 and LAST_SAMPLE=15.
//  Sub-module uart_baud_tick: BAUD_DIV counter with synchronous clear input and one-cycle tick output.
//  Top level holds the synchroniser, FSM, shreg, scnt/bcnt and output registers.
// TESTING
//  1. Reset: hold reset 3 cycles with rx_serial=1.
//     -> rx_rdy=1, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, rx_active=0.
//  2. Clean frame: send 0xA5 (LSB first) with a good stop bit.
//     -> rx_rdy low ~0.5 bit after the edge; one rx_valid pulse; rx_data=0xA5; rx_rdy=1; frame_err=0.
//  3. Glitch: rx_serial low for 3*BAUD_DIV cycles, then high.
//     -> returns to IDLE; rx_rdy stays 1; no rx_valid.
//  4. Framing error: send 0x3C with stop bit 0, hold the line low 2 bit times, then release.
//     -> rx_data=0x3C, rx_valid pulse, frame_err=1; no new frame until the line goes high.
//     Then send 0x55 -> frame_err clears at its start midpoint; rx_data=0x55.
//  5. Back-to-back and reset abort:
//     - 0x00 then 0xFF with no idle gap -> two rx_valid pulses, in order.
//     - reset asserted in the middle of bit 4 -> all outputs at reset values, no rx_valid.
//  6. Parity (macro defined, PARITY_ODD=0): 0x07 with parity bit 1 -> parity_err=0.
//     0x07 with parity bit 0 -> parity_err=1, rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and oversampling constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID_SAMPLE = SW'(7);
  localparam logic [SW-1:0] LAST_SAMPLE = SW'(15);
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: BAUD_DIV divider producing the 16x oversample tick, clearable on a start edge
module uart_baud_tick #(
  parameter int BAUD_DIV = 27
) (
  input  logic clka,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int CW = $clog2(BAUD_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(BAUD_DIV - 1);
  always_ff @(posedge clka)
    if (reset || clear || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: 16x oversampled UART receiver (start/8 data/stop); UART_RX_PARITY_EN adds a parity bit
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clka,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       frame_err,
  output logic       parity_err
);
  state_t state, nxt;
  logic s1, rxs, tick, clr, mid, last, confirm, done;
  logic [SW-1:0] scnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;

  uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clka  (clka),
    .reset (reset),
    .clear (clr),
    .tick  (tick)
  );

  assign clr       = state == IDLE && !rxs;
  assign mid       = tick && scnt == MID_SAMPLE;
  assign last      = tick && scnt == LAST_SAMPLE;
  assign confirm   = state == START && mid && !rxs;
  assign done      = state == STOP && last;
  assign rx_active = state != IDLE;

  always_ff @(posedge clka)
    if (reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = rxs ? IDLE : START;
      START:  nxt = mid ? (rxs ? IDLE : DATA) : START;
`ifdef UART_RX_PARITY_EN
      DATA:   nxt = (last && bcnt == 3'd7) ? PARITY : DATA;
      PARITY: nxt = last ? STOP : PARITY;
`else
      DATA:   nxt = (last && bcnt == 3'd7) ? STOP : DATA;
`endif
      STOP:   nxt = last ? (rxs ? IDLE : BREAK) : STOP;
      BREAK:  nxt = rxs ? IDLE : BREAK;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka)
    if (reset) begin
      {rxs, s1} <= 2'b11;
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_rdy    <= 1'b1;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      {rxs, s1} <= {s1, rx_serial};
      rx_valid  <= 1'b0;
      if (clr || confirm) scnt <= '0;
      else if (tick) scnt <= scnt + 1'b1;
      if (confirm) begin
        bcnt      <= '0;
        rx_rdy    <= 1'b0;
        frame_err <= 1'b0;
      end
      if (state == DATA && last) begin
        shreg <= {rxs, shreg[7:1]};
        bcnt  <= bcnt + 1'b1;
      end
      // byte is delivered even on a bad stop bit; frame_err qualifies it
      if (done) begin
        rx_data   <= shreg;
        rx_valid  <= 1'b1;
        rx_rdy    <= 1'b1;
        frame_err <= !rxs;
      end
    end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clka)
    if (reset || confirm) parity_err <= 1'b0;
    else if (state == PARITY && last && rxs != (^shreg ^ PARITY_ODD)) parity_err <= 1'b1;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: randomized frames checked against a queue-based model of delivered bytes
module tb_uart_rx_deserializer;
  localparam int BD  = 4;
  localparam int BIT = 16 * BD;
  localparam bit PO  = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic [7:0] rx_data;
  logic rx_rdy, rx_valid, rx_active, frame_err, parity_err;
  int tests = 0, fails = 0;
  logic [9:0] got_q[$], exp_q[$];

  uart_rx_deserializer #(.BAUD_DIV(BD), .PARITY_ODD(PO)) dut (
    .clka       (clk),
    .reset      (reset),
    .rx_serial  (rx),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .rx_valid   (rx_valid),
    .rx_active  (rx_active),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset && rx_valid) got_q.push_back({rx_data, frame_err, parity_err});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input bit v);
    rx = v;
    idle(BIT);
  endtask

  task automatic send(input logic [7:0] d, input bit stop, input bit pflip);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (PAR) bit_out(^d ^ PO ^ pflip);
    bit_out(stop);
  endtask

  task automatic frame(input logic [7:0] d, input bit stop, input bit pflip);
    exp_q.push_back({d, ~stop, pflip & PAR});
    send(d, stop, pflip);
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_frame"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"}, rx_rdy, 1);
    check({tag, "_data"}, rx_data, 0);
    check({tag, "_valid"}, rx_valid, 0);
    check({tag, "_fe"}, frame_err, 0);
    check({tag, "_pe"}, parity_err, 0);
    check({tag, "_active"}, rx_active, 0);
  endtask

  initial begin
    logic [7:0] d;
    bit stop, pf;
    idle(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(4);

    fork
      frame(8'hA5, 1'b1, 1'b0);
      begin
        idle(3 * BIT);
        check("busy_rdy", rx_rdy, 0);
        check("busy_active", rx_active, 1);
      end
    join
    idle(BIT);
    check("clean_rdy", rx_rdy, 1);
    check("clean_data", rx_data, 8'hA5);
    compare("clean");

    rx = 1'b0;
    idle(3 * BD);
    rx = 1'b1;
    idle(2 * BIT);
    check("glitch_rdy", rx_rdy, 1);
    check("glitch_active", rx_active, 0);
    compare("glitch");

    frame(8'h3C, 1'b0, 1'b0);
    idle(2 * BIT);
    check("break_active", rx_active, 1);
    check("break_no_restart", got_q.size(), 1);
    rx = 1'b1;
    idle(BIT);
    check("ferr_flag", frame_err, 1);
    check("ferr_data", rx_data, 8'h3C);
    fork
      frame(8'h55, 1'b1, 1'b0);
      begin
        idle(2 * BIT);
        check("ferr_clear", frame_err, 0);
      end
    join
    idle(BIT);
    compare("ferr");

    frame(8'h00, 1'b1, 1'b0);
    frame(8'hFF, 1'b1, 1'b0);
    idle(BIT);
    compare("b2b");

    // upper nibble (and parity bit) high so the line stays idle after the abort
    d = 8'hF0 | 8'($urandom_range(0, 15));
    if (PAR && !(^d ^ PO)) d[0] = ~d[0];
    fork
      send(d, 1'b1, 1'b0);
      begin
        idle(BIT * 11 / 2);
        reset = 1'b1;
        idle(2);
        check_reset_outputs("abort");
        reset = 1'b0;
      end
    join
    idle(2 * BIT);
    compare("abort");

    if (PAR) begin
      frame(8'h07, 1'b1, 1'b0);
      idle(BIT);
      check("par_ok", parity_err, 0);
      frame(8'h07, 1'b1, 1'b1);
      idle(BIT);
      check("par_bad", parity_err, 1);
      check("par_data", rx_data, 8'h07);
      compare("parity");
    end

    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      stop = $urandom_range(0, 5) != 0;
      pf = PAR ? 1'($urandom_range(0, 1)) : 1'b0;
      frame(d, stop, pf);
      if (!stop) begin
        rx = 1'b1;
        idle(4 + $urandom_range(0, BIT));
      end else if ($urandom_range(0, 1) != 0) idle($urandom_range(1, BIT));
    end
    idle(BIT);
    compare("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
